// File: rtl/pi_controller_if.sv
// PI bus: device requests, CONO/CONI PI access and the CPU interrupt handshake.
// The master side is the CPU and devices; the slave side is the PI controller.
interface pi_controller_if;
  logic [1:7]   io_req;
  logic         cono_pi;
  logic [18:35] cono_data;
  logic [0:35]  coni_pi;
  logic         int_req;
  logic [2:0]   int_level;
  logic         int_ack;
  logic         int_done;
  logic         int_hold;
  logic         int_dismiss;

  modport master (
    output io_req, cono_pi, cono_data, int_ack, int_done, int_hold, int_dismiss,
    input  coni_pi, int_req, int_level
  );

  modport slave (
    input  io_req, cono_pi, cono_data, int_ack, int_done, int_hold, int_dismiss,
    output coni_pi, int_req, int_level
  );
endinterface

// File: rtl/pi_controller.sv
// Seven-level priority interrupt controller; int_req/int_level are registered one cycle after eligibility.
// Program requests (CONO 22/24, CONI 11-17) exist only when PI_PROG_REQ_EN is defined.
module pi_controller (
  input  logic           clk,
  input  logic           reset_n,
  pi_controller_if.slave pi
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, EXEC = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        pi_on_q, pi_on_d;
  logic [1:7]  level_on_q, level_on_d;
  logic [1:7]  in_prog_q, in_prog_d;
  logic [1:7]  prog_req_q;
  logic        int_req_q, int_req_d;
  logic [2:0]  int_level_q, int_level_d;
  logic [2:0]  lvl_latch_q, lvl_latch_d;
  logic [1:7]  sel;
  logic [2:0]  elig_lvl;
  logic        blocked;
  logic        dismissed;
  logic [0:35] coni;

  assign sel = pi.cono_data[29:35];

  // Lowest eligible level; an active level masks itself and everything below it.
  always_comb begin
    elig_lvl = 3'd0;
    blocked  = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      blocked = blocked | in_prog_q[n];
      if (elig_lvl == 3'd0 && !blocked && pi_on_q &&
          ((pi.io_req[n] & level_on_q[n]) | prog_req_q[n]))
        elig_lvl = 3'(n);
    end
  end

  always_comb begin
    state_d     = state_q;
    pi_on_d     = pi_on_q;
    level_on_d  = level_on_q;
    in_prog_d   = in_prog_q;
    int_req_d   = int_req_q;
    int_level_d = int_level_q;
    lvl_latch_d = lvl_latch_q;
    dismissed   = 1'b0;

    if (pi.int_dismiss) begin
      for (int n = 1; n <= 7; n++) begin
        if (!dismissed && in_prog_q[n]) begin
          in_prog_d[n] = 1'b0;
          dismissed    = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (elig_lvl != 3'd0) begin
          state_d     = REQ;
          int_req_d   = 1'b1;
          int_level_d = elig_lvl;
        end
      end
      REQ: begin
        if (pi.int_ack) begin
          state_d                = EXEC;
          in_prog_d[int_level_q] = 1'b1;
          lvl_latch_d            = int_level_q;
          int_req_d              = 1'b0;
          int_level_d            = 3'd0;
        end else if (elig_lvl != 3'd0) begin
          int_level_d = elig_lvl;
        end else begin
          state_d     = IDLE;
          int_req_d   = 1'b0;
          int_level_d = 3'd0;
        end
      end
      EXEC: begin
        if (pi.int_done) begin
          if (!pi.int_hold)
            in_prog_d[lvl_latch_q] = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear PI overrides the interrupt handshake of the same cycle.
    if (pi.cono_pi) begin
      if (pi.cono_data[23]) begin
        pi_on_d     = 1'b0;
        level_on_d  = '0;
        in_prog_d   = '0;
        state_d     = IDLE;
        int_req_d   = 1'b0;
        int_level_d = 3'd0;
      end else begin
        if (pi.cono_data[28])
          pi_on_d = 1'b1;
        else if (pi.cono_data[27])
          pi_on_d = 1'b0;
        if (pi.cono_data[25])
          level_on_d = level_on_q | sel;
        else if (pi.cono_data[26])
          level_on_d = level_on_q & ~sel;
      end
    end
  end

`ifdef PI_PROG_REQ_EN
  logic [1:7] prog_req_d;
  logic [1:7] ack_mask;
  logic       unused_cono;

  assign unused_cono = ^pi.cono_data[18:21];

  always_comb begin
    ack_mask = '0;
    if (state_q == REQ && pi.int_ack)
      ack_mask[int_level_q] = 1'b1;
    prog_req_d = prog_req_q & ~ack_mask;
    if (pi.cono_pi) begin
      if (pi.cono_data[23])
        prog_req_d = '0;
      else if (pi.cono_data[24])
        prog_req_d = prog_req_d | sel;
      else if (pi.cono_data[22])
        prog_req_d = prog_req_d & ~sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      prog_req_q <= '0;
    else
      prog_req_q <= prog_req_d;
  end
`else
  logic unused_cono;

  assign unused_cono = ^{pi.cono_data[18:22], pi.cono_data[24]};
  assign prog_req_q  = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pi_on_q     <= 1'b0;
      level_on_q  <= '0;
      in_prog_q   <= '0;
      int_req_q   <= 1'b0;
      int_level_q <= 3'd0;
      lvl_latch_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      pi_on_q     <= pi_on_d;
      level_on_q  <= level_on_d;
      in_prog_q   <= in_prog_d;
      int_req_q   <= int_req_d;
      int_level_q <= int_level_d;
      lvl_latch_q <= lvl_latch_d;
    end
  end

  always_comb begin
    coni        = '0;
    coni[11:17] = prog_req_q;
    coni[21:27] = in_prog_q;
    coni[28]    = pi_on_q;
    coni[29:35] = level_on_q;
  end

  assign pi.coni_pi   = coni;
  assign pi.int_req   = int_req_q;
  assign pi.int_level = int_level_q;
endmodule

// File: tb/tb_pi_controller.sv
// Bench for pi_controller: directed scenarios plus random traffic against a set-based reference model.
module tb_pi_controller;
  logic clk = 1'b0;
  logic reset_n;
  pi_controller_if bus();

  pi_controller dut (.clk(clk), .reset_n(reset_n), .pi(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: levels as sets of flags, phase 0 idle / 1 requesting / 2 executing.
  bit m_pi_on;
  bit m_on[1:7];
  bit m_prog[1:7];
  bit m_inprog[1:7];
  int m_phase;
  bit m_req;
  int m_lvl;
  int m_latch;

  function automatic logic [18:35] cbit(int p);
    logic [18:35] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic int first_active();
    for (int n = 1; n <= 7; n++) if (m_inprog[n]) return n;
    return 8;
  endfunction

  function automatic int pick();
    int lim;
    lim = first_active();
    if (!m_pi_on) return 0;
    for (int n = 1; n < lim; n++)
      if ((bus.io_req[n] && m_on[n]) || m_prog[n]) return n;
    return 0;
  endfunction

  function automatic logic [0:35] exp_coni();
    logic [0:35] w;
    w = '0;
    for (int n = 1; n <= 7; n++) begin
      w[10+n] = m_prog[n];
      w[20+n] = m_inprog[n];
      w[28+n] = m_on[n];
    end
    w[28] = m_pi_on;
    return w;
  endfunction

  task automatic model_reset();
    m_pi_on = 0; m_phase = 0; m_req = 0; m_lvl = 0; m_latch = 0;
    for (int n = 1; n <= 7; n++) begin m_on[n] = 0; m_prog[n] = 0; m_inprog[n] = 0; end
  endtask

  task automatic clear_strobes();
    bus.cono_pi = 0; bus.cono_data = '0; bus.int_ack = 0;
    bus.int_done = 0; bus.int_hold = 0; bus.int_dismiss = 0;
  endtask

  // One clock with the currently driven inputs; the model advances alongside.
  task automatic step();
    bit nin[1:7]; bit non[1:7]; bit nprog[1:7];
    bit npi; int nph; bit nreq; int nlvl; int nlat; int e; int lv;
    nin = m_inprog; non = m_on; nprog = m_prog; npi = m_pi_on;
    nph = m_phase; nreq = m_req; nlvl = m_lvl; nlat = m_latch;
    e  = pick();
    lv = first_active();
    if (bus.int_dismiss && lv < 8) nin[lv] = 0;
    if (m_phase == 0) begin
      if (e != 0) begin nph = 1; nreq = 1; nlvl = e; end
    end else if (m_phase == 1) begin
      if (bus.int_ack) begin
        nin[m_lvl] = 1; nprog[m_lvl] = 0; nlat = m_lvl; nph = 2; nreq = 0; nlvl = 0;
      end else if (e != 0) nlvl = e;
      else begin nph = 0; nreq = 0; nlvl = 0; end
    end else if (bus.int_done) begin
      if (!bus.int_hold) nin[m_latch] = 0;
      nph = 0;
    end
    if (bus.cono_pi) begin
      if (bus.cono_data[23]) begin
        npi = 0; nph = 0; nreq = 0; nlvl = 0;
        for (int n = 1; n <= 7; n++) begin non[n] = 0; nprog[n] = 0; nin[n] = 0; end
      end else begin
        if (bus.cono_data[28]) npi = 1; else if (bus.cono_data[27]) npi = 0;
        for (int n = 1; n <= 7; n++) begin
          if (bus.cono_data[28+n]) begin
            if (bus.cono_data[25]) non[n] = 1; else if (bus.cono_data[26]) non[n] = 0;
`ifdef PI_PROG_REQ_EN
            if (bus.cono_data[24]) nprog[n] = 1; else if (bus.cono_data[22]) nprog[n] = 0;
`endif
          end
        end
      end
    end
    @(posedge clk); #1;
    m_inprog = nin; m_on = non; m_prog = nprog; m_pi_on = npi;
    m_phase = nph; m_req = nreq; m_lvl = nlvl; m_latch = nlat;
    clear_strobes();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.io_req = '0;
    clear_strobes();
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic enable_all();
    bus.cono_pi   = 1;
    bus.cono_data = 18'o000177 | cbit(25) | cbit(28);
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.io_req = '0;
    clear_strobes();
    model_reset();
    #3;
    total++; if (bus.int_req !== 1'b0) begin bad++; $display("FAIL reset_int_req: got %b want 0", bus.int_req); end
    total++; if (bus.int_level !== 3'd0) begin bad++; $display("FAIL reset_int_level: got %0d want 0", bus.int_level); end
    total++; if (bus.coni_pi !== 36'd0) begin bad++; $display("FAIL reset_coni: got %o want 0", bus.coni_pi); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.io_req = 7'h7f;
    step();
    total++; if (bus.int_req !== 1'b0) begin bad++; $display("FAIL reset_pi_off: got %b want 0", bus.int_req); end
    bus.io_req = '0;
  endtask

  task automatic test_enable();
    do_reset();
    enable_all();
    total++; if (bus.coni_pi[28] !== 1'b1) begin bad++; $display("FAIL enable_pi_on: got %b want 1", bus.coni_pi[28]); end
    total++; if (bus.coni_pi[29:35] !== 7'h7f) begin bad++; $display("FAIL enable_levels: got %b want 1111111", bus.coni_pi[29:35]); end
    bus.io_req[3] = 1'b1;
    step();
    total++; if (bus.int_req !== 1'b1) begin bad++; $display("FAIL enable_req: got %b want 1", bus.int_req); end
    total++; if (bus.int_level !== 3'd3) begin bad++; $display("FAIL enable_level: got %0d want 3", bus.int_level); end
    bus.io_req = '0;
  endtask

  task automatic test_hold();
    do_reset();
    enable_all();
    bus.io_req[5] = 1'b1;
    step();
    total++; if (bus.int_level !== 3'd5) begin bad++; $display("FAIL hold_level5: got %0d want 5", bus.int_level); end
    bus.int_ack = 1;
    step();
    bus.io_req = '0;
    total++; if (bus.int_req !== 1'b0 || bus.coni_pi[25] !== 1'b1) begin bad++; $display("FAIL hold_ack: got req=%b inprog5=%b want 0/1", bus.int_req, bus.coni_pi[25]); end
    bus.int_done = 1; bus.int_hold = 1;
    step();
    total++; if (bus.coni_pi[25] !== 1'b1) begin bad++; $display("FAIL hold_kept: got %b want 1", bus.coni_pi[25]); end
    bus.io_req[6] = 1'b1;
    step(); step();
    total++; if (bus.int_req !== 1'b0) begin bad++; $display("FAIL hold_block6: got %b want 0", bus.int_req); end
    bus.io_req = '0; bus.io_req[2] = 1'b1;
    step();
    total++; if (bus.int_req !== 1'b1 || bus.int_level !== 3'd2) begin bad++; $display("FAIL hold_level2: got req=%b lvl=%0d want 1/2", bus.int_req, bus.int_level); end
    bus.io_req = '0;
  endtask

  task automatic test_done();
    do_reset();
    enable_all();
    bus.io_req[4] = 1'b1;
    step();
    bus.int_ack = 1;
    step();
    bus.io_req = '0;
    bus.int_done = 1; bus.int_hold = 0;
    step();
    total++; if (bus.coni_pi[24] !== 1'b0) begin bad++; $display("FAIL done_inprog4: got %b want 0", bus.coni_pi[24]); end
    total++; if (bus.int_req !== 1'b0) begin bad++; $display("FAIL done_req: got %b want 0", bus.int_req); end
    bus.io_req[4] = 1'b1;
    step();
    total++; if (bus.int_req !== 1'b1 || bus.int_level !== 3'd4) begin bad++; $display("FAIL done_idle: got req=%b lvl=%0d want 1/4", bus.int_req, bus.int_level); end
    bus.io_req = '0;
  endtask

  task automatic test_dismiss();
    do_reset();
    enable_all();
    bus.io_req[6] = 1'b1; step();
    bus.int_ack = 1; step();
    bus.io_req = '0;
    bus.int_done = 1; bus.int_hold = 1; step();
    bus.io_req[2] = 1'b1; step();
    bus.int_ack = 1; step();
    bus.io_req = '0;
    bus.int_done = 1; bus.int_hold = 1; step();
    total++; if (bus.coni_pi[21:27] !== 7'b0100010) begin bad++; $display("FAIL dismiss_setup: got %b want 0100010", bus.coni_pi[21:27]); end
    bus.int_dismiss = 1; step();
    total++; if (bus.coni_pi[21:27] !== 7'b0000010) begin bad++; $display("FAIL dismiss_first: got %b want 0000010", bus.coni_pi[21:27]); end
    bus.int_dismiss = 1; step();
    total++; if (bus.coni_pi[21:27] !== 7'b0000000) begin bad++; $display("FAIL dismiss_second: got %b want 0000000", bus.coni_pi[21:27]); end
  endtask

  task automatic test_clear_ack();
    do_reset();
    enable_all();
    bus.io_req[3] = 1'b1;
    step();
    bus.cono_pi = 1; bus.cono_data = cbit(23); bus.int_ack = 1;
    step();
    total++; if (bus.int_req !== 1'b0) begin bad++; $display("FAIL clear_req: got %b want 0", bus.int_req); end
    total++; if (bus.coni_pi !== 36'd0) begin bad++; $display("FAIL clear_coni: got %o want 0", bus.coni_pi); end
    enable_all();
    step();
    total++; if (bus.int_req !== 1'b1 || bus.int_level !== 3'd3) begin bad++; $display("FAIL clear_idle: got req=%b lvl=%0d want 1/3", bus.int_req, bus.int_level); end
    bus.io_req = '0;
  endtask

  task automatic test_prog();
    do_reset();
    bus.cono_pi = 1; bus.cono_data = cbit(24) | cbit(28) | cbit(35);
    step();
`ifdef PI_PROG_REQ_EN
    total++; if (bus.coni_pi[17] !== 1'b1) begin bad++; $display("FAIL prog_set: got %b want 1", bus.coni_pi[17]); end
    step();
    total++; if (bus.int_req !== 1'b1 || bus.int_level !== 3'd7) begin bad++; $display("FAIL prog_req7: got req=%b lvl=%0d want 1/7", bus.int_req, bus.int_level); end
    bus.int_ack = 1;
    step();
    total++; if (bus.coni_pi[17] !== 1'b0 || bus.coni_pi[27] !== 1'b1) begin bad++; $display("FAIL prog_ack: got prog7=%b inprog7=%b want 0/1", bus.coni_pi[17], bus.coni_pi[27]); end
`else
    total++; if (bus.coni_pi[11:17] !== 7'd0) begin bad++; $display("FAIL prog_bits: got %b want 0", bus.coni_pi[11:17]); end
    step();
    total++; if (bus.int_req !== 1'b0) begin bad++; $display("FAIL prog_noreq: got %b want 0", bus.int_req); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable_all();
    bus.io_req[1] = 1'b1;
    step();
    reset_n = 1'b0;
    #1;
    total++; if (bus.int_req !== 1'b0 || bus.int_level !== 3'd0) begin bad++; $display("FAIL midreset_req: got req=%b lvl=%0d want 0/0", bus.int_req, bus.int_level); end
    total++; if (bus.coni_pi !== 36'd0) begin bad++; $display("FAIL midreset_coni: got %o want 0", bus.coni_pi); end
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.int_req !== 1'b0) begin bad++; $display("FAIL midreset_quiet: got %b want 0", bus.int_req); end
    end
    bus.io_req = '0;
  endtask

  task automatic test_random();
    do_reset();
    enable_all();
    for (int i = 0; i < 400; i++) begin
      bus.io_req    = 7'($urandom) & 7'($urandom);
      bus.cono_pi   = ($urandom_range(0, 7) == 0);
      bus.cono_data = 18'($urandom);
      if ($urandom_range(0, 15) != 0) bus.cono_data[23] = 1'b0;
      bus.int_ack     = ($urandom_range(0, 2) == 0);
      bus.int_done    = ($urandom_range(0, 2) == 0);
      bus.int_hold    = 1'($urandom);
      bus.int_dismiss = ($urandom_range(0, 9) == 0);
      step();
      total++; if (bus.int_req !== m_req) begin bad++; $display("FAIL rand_req[%0d]: got %b want %b", i, bus.int_req, m_req); end
      total++; if (bus.int_level !== 3'(m_lvl)) begin bad++; $display("FAIL rand_level[%0d]: got %0d want %0d", i, bus.int_level, m_lvl); end
      total++; if (bus.coni_pi !== exp_coni()) begin bad++; $display("FAIL rand_coni[%0d]: got %o want %o", i, bus.coni_pi, exp_coni()); end
    end
    bus.io_req = '0;
  endtask

  initial begin
    test_reset();
    test_enable();
    test_hold();
    test_done();
    test_dismiss();
    test_clear_ack();
    test_prog();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
